// File: rtl/mb_sched_pkg.sv
// Shared definitions for the macroblock motion-estimation scheduler.
//   mb_state_t : scheduler FSM state encoding
//   range_t    : search-range code carried to the fetch controller
//   CUR_SHIFT / REF_SHIFT : per-macroblock address strides (32 and 64)
//   mb_addr()  : linear macroblock index -> 12-bit base address
package mb_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SEARCH = 3'd2,
        ST_EMIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } mb_state_t;

    typedef logic [1:0] range_t;

    localparam int unsigned CUR_SHIFT = 5;   // 32 bytes per current macroblock
    localparam int unsigned REF_SHIFT = 6;   // 64 bytes per reference window

    localparam logic [15:0] SAD_MAX = 16'hFFFF;

    // Addresses are 12 bits wide; larger frames simply wrap.
    function automatic logic [11:0] mb_addr(input logic [7:0] idx, input int unsigned shift);
        logic [11:0] w;
        w = {4'd0, idx};
        return w << shift;
    endfunction

endpackage

// File: rtl/sad_best_track.sv
// Best-match tracker: keeps the lowest SAD seen during one search and
// freezes it into the result registers when the search ends.
//   init       : start of a new macroblock search (clears the best)
//   en         : search window open, candidates are considered
//   freeze     : last search cycle; a candidate in this cycle still counts
//   sad_valid / sad / mv_x / mv_y : candidate input
//   frz_sad / frz_mv_x / frz_mv_y : frozen best match (0 after reset)
module sad_best_track
    import mb_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        freeze,
    input  logic        sad_valid,
    input  logic [15:0] sad,
    input  logic [5:0]  mv_x,
    input  logic [5:0]  mv_y,
    output logic [15:0] frz_sad,
    output logic [5:0]  frz_mv_x,
    output logic [5:0]  frz_mv_y
);

    logic [15:0] best_sad;
    logic [5:0]  best_mv_x;
    logic [5:0]  best_mv_y;
    logic        first_seen;
    logic        take;
    logic [15:0] nxt_sad;
    logic [5:0]  nxt_mv_x;
    logic [5:0]  nxt_mv_y;

    // Strict less-than: on a tie the earlier candidate is kept.
    assign take = en && sad_valid && (!first_seen || (sad < best_sad));

    // Best including this cycle's candidate, so the freeze sees it.
    always_comb begin
        nxt_sad  = best_sad;
        nxt_mv_x = best_mv_x;
        nxt_mv_y = best_mv_y;
        if (take) begin
            nxt_sad  = sad;
            nxt_mv_x = mv_x;
            nxt_mv_y = mv_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_sad   <= SAD_MAX;
            best_mv_x  <= '0;
            best_mv_y  <= '0;
            first_seen <= 1'b0;
            frz_sad    <= '0;
            frz_mv_x   <= '0;
            frz_mv_y   <= '0;
        end else begin
            if (init) begin
                best_sad   <= SAD_MAX;
                best_mv_x  <= '0;
                best_mv_y  <= '0;
                first_seen <= 1'b0;
            end else if (take) begin
                best_sad   <= sad;
                best_mv_x  <= mv_x;
                best_mv_y  <= mv_y;
                first_seen <= 1'b1;
            end
            if (freeze) begin
                frz_sad  <= nxt_sad;
                frz_mv_x <= nxt_mv_x;
                frz_mv_y <= nxt_mv_y;
            end
        end
    end

endmodule

// File: rtl/mb_sched.sv
// Macroblock scheduler: walks a frame in raster order, launches one motion
// search per macroblock, tracks the best SAD candidate and hands each result
// to a ready/valid consumer.
//   frame_go/r_cfg       : frame request and search-range code (IDLE only)
//   me_go/me_r           : launch pulse and latched range to the fetch block
//   cur_base/ref_base    : registered base addresses of the current macroblock
//   me_done, sad_valid, sad, mv_x, mv_y : search completion and candidates
//   res_valid/res_ready, res_* : per-macroblock result handshake
//   busy, frame_done, timeout_err : status
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for frame_go
// LAUNCH    | me_go high for this cycle, best-match tracker cleared
// SEARCH    | collecting candidates until me_done or timeout
// EMIT      | result valid, waiting for res_ready
// NEXT      | advance macroblock position and base addresses
// FINISH    | frame_done high for this cycle
module mb_sched
    import mb_sched_pkg::*;
#(
    parameter int MB_COLS = 4,
    parameter int MB_ROWS = 4,
    parameter int TIMEOUT = 8191
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_go,
    input  logic [1:0]  r_cfg,
    output logic        me_go,
    output logic [1:0]  me_r,
    output logic [11:0] cur_base,
    output logic [11:0] ref_base,
    input  logic        me_done,
    input  logic        sad_valid,
    input  logic [15:0] sad,
    input  logic [5:0]  mv_x,
    input  logic [5:0]  mv_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_mb_x,
    output logic [3:0]  res_mb_y,
    output logic [15:0] res_sad,
    output logic [5:0]  res_mv_x,
    output logic [5:0]  res_mv_y,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    mb_state_t   state;
    logic [3:0]  mb_x;
    logic [3:0]  mb_y;
    logic [7:0]  mb_idx;
    logic [TW-1:0] timer;
    logic        search_end;
    logic        last_mb;
    logic        trk_init;
    logic        trk_en;

    // Timer is loaded in LAUNCH so that the terminal count lands exactly
    // TIMEOUT cycles after me_go; me_done in that same cycle wins.
    assign search_end = (state == ST_SEARCH) && (me_done || (timer <= TW'(1)));
    assign last_mb    = (mb_x == 4'(MB_COLS - 1)) && (mb_y == 4'(MB_ROWS - 1));
    assign trk_init   = (state == ST_LAUNCH);
    assign trk_en     = (state == ST_SEARCH);

    sad_best_track u_track (
        .clk       (clk),
        .reset     (reset),
        .init      (trk_init),
        .en        (trk_en),
        .freeze    (search_end),
        .sad_valid (sad_valid),
        .sad       (sad),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .frz_sad   (res_sad),
        .frz_mv_x  (res_mv_x),
        .frz_mv_y  (res_mv_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            mb_x        <= '0;
            mb_y        <= '0;
            mb_idx      <= '0;
            timer       <= '0;
            me_go       <= 1'b0;
            me_r        <= '0;
            cur_base    <= '0;
            ref_base    <= '0;
            res_valid   <= 1'b0;
            res_mb_x    <= '0;
            res_mb_y    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            me_go      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_go) begin
                        mb_x        <= '0;
                        mb_y        <= '0;
                        mb_idx      <= '0;
                        cur_base    <= '0;
                        ref_base    <= '0;
                        me_r        <= range_t'(r_cfg);
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        me_go       <= 1'b1;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timer <= TW'(TIMEOUT - 1);
                    state <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (search_end) begin
                        if (!me_done) begin
                            timeout_err <= 1'b1;
                        end
                        res_valid <= 1'b1;
                        res_mb_x  <= mb_x;
                        res_mb_y  <= mb_y;
                        state     <= ST_EMIT;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (last_mb) begin
                        frame_done <= 1'b1;
                        state      <= ST_FINISH;
                    end else begin
                        if (mb_x == 4'(MB_COLS - 1)) begin
                            mb_x <= '0;
                            mb_y <= mb_y + 4'd1;
                        end else begin
                            mb_x <= mb_x + 4'd1;
                        end
                        mb_idx   <= mb_idx + 8'd1;
                        cur_base <= mb_addr(mb_idx + 8'd1, CUR_SHIFT);
                        ref_base <= mb_addr(mb_idx + 8'd1, REF_SHIFT);
                        me_go    <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb_sched.sv
// Bench for mb_sched: two 2x2 instances (default timeout and TIMEOUT=50)
// share stimulus; sel_b picks which one is observed. Candidate SADs are
// random and the expected best match is the first candidate holding the
// minimum SAD among those offered inside the search window.
module tb_mb_sched;

    localparam int TO_B = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        frame_go, me_done, sad_valid, res_ready, sel_b;
    logic [1:0]  r_cfg;
    logic [15:0] sad;
    logic [5:0]  mv_x, mv_y;

    logic        a_me_go, a_res_valid, a_busy, a_frame_done, a_timeout_err;
    logic [1:0]  a_me_r;
    logic [11:0] a_cur_base, a_ref_base;
    logic [3:0]  a_res_mb_x, a_res_mb_y;
    logic [15:0] a_res_sad;
    logic [5:0]  a_res_mv_x, a_res_mv_y;
    logic        b_me_go, b_res_valid, b_busy, b_frame_done, b_timeout_err;
    logic [1:0]  b_me_r;
    logic [11:0] b_cur_base, b_ref_base;
    logic [3:0]  b_res_mb_x, b_res_mb_y;
    logic [15:0] b_res_sad;
    logic [5:0]  b_res_mv_x, b_res_mv_y;

    logic        o_me_go, o_res_valid, o_busy, o_frame_done, o_timeout_err;
    logic [1:0]  o_me_r;
    logic [11:0] o_cur_base, o_ref_base;
    logic [3:0]  o_res_mb_x, o_res_mb_y;
    logic [15:0] o_res_sad;
    logic [5:0]  o_res_mv_x, o_res_mv_y;

    assign o_me_go       = sel_b ? b_me_go       : a_me_go;
    assign o_res_valid   = sel_b ? b_res_valid   : a_res_valid;
    assign o_busy        = sel_b ? b_busy        : a_busy;
    assign o_frame_done  = sel_b ? b_frame_done  : a_frame_done;
    assign o_timeout_err = sel_b ? b_timeout_err : a_timeout_err;
    assign o_me_r        = sel_b ? b_me_r        : a_me_r;
    assign o_cur_base    = sel_b ? b_cur_base    : a_cur_base;
    assign o_ref_base    = sel_b ? b_ref_base    : a_ref_base;
    assign o_res_mb_x    = sel_b ? b_res_mb_x    : a_res_mb_x;
    assign o_res_mb_y    = sel_b ? b_res_mb_y    : a_res_mb_y;
    assign o_res_sad     = sel_b ? b_res_sad     : a_res_sad;
    assign o_res_mv_x    = sel_b ? b_res_mv_x    : a_res_mv_x;
    assign o_res_mv_y    = sel_b ? b_res_mv_y    : a_res_mv_y;

    mb_sched #(.MB_COLS(2), .MB_ROWS(2)) dut_a (
        .clk(clk), .reset(reset), .frame_go(frame_go), .r_cfg(r_cfg),
        .me_go(a_me_go), .me_r(a_me_r), .cur_base(a_cur_base), .ref_base(a_ref_base),
        .me_done(me_done), .sad_valid(sad_valid), .sad(sad), .mv_x(mv_x), .mv_y(mv_y),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_mb_x(a_res_mb_x),
        .res_mb_y(a_res_mb_y), .res_sad(a_res_sad), .res_mv_x(a_res_mv_x),
        .res_mv_y(a_res_mv_y), .busy(a_busy), .frame_done(a_frame_done),
        .timeout_err(a_timeout_err)
    );

    mb_sched #(.MB_COLS(2), .MB_ROWS(2), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset(reset), .frame_go(frame_go), .r_cfg(r_cfg),
        .me_go(b_me_go), .me_r(b_me_r), .cur_base(b_cur_base), .ref_base(b_ref_base),
        .me_done(me_done), .sad_valid(sad_valid), .sad(sad), .mv_x(mv_x), .mv_y(mv_y),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_mb_x(b_res_mb_x),
        .res_mb_y(b_res_mb_y), .res_sad(b_res_sad), .res_mv_x(b_res_mv_x),
        .res_mv_y(b_res_mv_y), .busy(b_busy), .frame_done(b_frame_done),
        .timeout_err(b_timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int go_cnt = 0;
    int fd_cnt = 0;
    int hs_cyc = 0;
    logic exp_tmo = 1'b0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (o_me_go === 1'b1) go_cnt++;
        if (o_frame_done === 1'b1) fd_cnt++;
    end

    // Candidate plan for one search: entry k-1 is driven in search cycle k.
    logic        pv  [0:127];
    logic [15:0] ps  [0:127];
    logic [5:0]  pmx [0:127];
    logic [5:0]  pmy [0:127];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic plan_random(input int n);
        for (int i = 0; i < n; i++) begin
            pv[i]  = ($urandom % 3) != 0;
            ps[i]  = 16'($urandom_range(0, 63));
            pmx[i] = 6'($urandom);
            pmy[i] = 6'($urandom);
        end
    endtask

    // Minimum SAD over the offered candidates, then the first one holding it.
    task automatic best_of(input int n, output logic [15:0] s, output logic [5:0] mx,
                           output logic [5:0] my);
        int mn;
        mn = 65536;
        s = 16'hFFFF;
        mx = '0;
        my = '0;
        for (int i = 0; i < n; i++)
            if (pv[i] && int'(ps[i]) < mn) mn = int'(ps[i]);
        for (int i = n - 1; i >= 0; i--)
            if (pv[i] && int'(ps[i]) == mn) begin
                s = ps[i];
                mx = pmx[i];
                my = pmy[i];
            end
    endtask

    task automatic chk_zero_outputs(input string p);
        chk({p, "_me_go"}, o_me_go, 0);
        chk({p, "_res_valid"}, o_res_valid, 0);
        chk({p, "_busy"}, o_busy, 0);
        chk({p, "_frame_done"}, o_frame_done, 0);
        chk({p, "_timeout_err"}, o_timeout_err, 0);
        chk({p, "_me_r"}, o_me_r, 0);
        chk({p, "_cur_base"}, o_cur_base, 0);
        chk({p, "_ref_base"}, o_ref_base, 0);
        chk({p, "_res_mb_x"}, o_res_mb_x, 0);
        chk({p, "_res_mb_y"}, o_res_mb_y, 0);
        chk({p, "_res_sad"}, o_res_sad, 0);
        chk({p, "_res_mv_x"}, o_res_mv_x, 0);
        chk({p, "_res_mv_y"}, o_res_mv_y, 0);
    endtask

    // One macroblock: launch, search, result handshake. Ends at the
    // negedge of the cycle after the handshake.
    task automatic do_mb(input int ex, input int ey, input int r, input int len,
                         input bit use_done, input int hold, input bit intrude, input bit gap);
        int w;
        int t_go;
        logic [15:0] es;
        logic [5:0] emx, emy;
        if (hold > 0) res_ready = 1'b0;
        w = 0;
        while (o_me_go !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("me_go_seen", o_me_go, 1);
        t_go = cyc;
        if (gap) chk("go_after_handshake", t_go - hs_cyc, 2);
        chk("cur_base", o_cur_base, (ey * 2 + ex) * 32);
        chk("ref_base", o_ref_base, (ey * 2 + ex) * 64);
        chk("me_r", o_me_r, r);
        chk("busy_search", o_busy, 1);
        chk("timeout_err_launch", o_timeout_err, exp_tmo);
        // Candidate in the launch cycle lies outside the window.
        sad_valid = 1'b1;
        sad = 16'd0;
        mv_x = 6'h15;
        mv_y = 6'h15;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) chk("res_valid_in_search", o_res_valid, 0);
            sad_valid = pv[k-1];
            sad = ps[k-1];
            mv_x = pmx[k-1];
            mv_y = pmy[k-1];
            me_done = use_done && (k == len);
            frame_go = intrude && (k == 2);
            if (intrude && k == 2) r_cfg = 2'(r ^ 3);
        end
        @(negedge clk);
        sad_valid = 1'b0;
        me_done = 1'b0;
        frame_go = 1'b0;
        w = 0;
        while (o_res_valid !== 1'b1 && w < 80) begin
            @(negedge clk);
            w++;
        end
        chk("res_valid_up", o_res_valid, 1);
        chk("emit_latency", cyc - t_go, use_done ? len + 1 : TO_B);
        if (!use_done) exp_tmo = 1'b1;
        best_of(len, es, emx, emy);
        chk("res_mb_x", o_res_mb_x, ex);
        chk("res_mb_y", o_res_mb_y, ey);
        chk("res_sad", o_res_sad, es);
        chk("res_mv_x", o_res_mv_x, emx);
        chk("res_mv_y", o_res_mv_y, emy);
        chk("timeout_err_emit", o_timeout_err, exp_tmo);
        if (hold == 0) begin
            hs_cyc = cyc;
        end else begin
            for (int i = 1; i <= hold; i++) begin
                @(negedge clk);
                sad_valid = 1'b1;
                sad = 16'd0;
                me_done = 1'b1;
                chk("hold_valid", o_res_valid, 1);
                chk("hold_sad", o_res_sad, es);
                chk("hold_mv_x", o_res_mv_x, emx);
                chk("hold_mv_y", o_res_mv_y, emy);
                chk("hold_mb_x", o_res_mb_x, ex);
                chk("hold_no_me_go", o_me_go, 0);
            end
            res_ready = 1'b1;
            hs_cyc = cyc;
        end
        @(negedge clk);
        sad_valid = 1'b0;
        me_done = 1'b0;
        chk("res_valid_drop", o_res_valid, 0);
    endtask

    // mode 1: MB0 uses the fixed tie-break sequence, MB1 puts its best
    // candidate in the me_done cycle and stalls the consumer for 20 cycles.
    task automatic run_frame(input int r, input int len, input bit use_done,
                             input int mode, input bit intrude);
        int go0, fd0, l, w;
        go0 = go_cnt;
        fd0 = fd_cnt;
        @(negedge clk);
        frame_go = 1'b1;
        r_cfg = 2'(r);
        @(negedge clk);
        frame_go = 1'b0;
        exp_tmo = 1'b0;
        chk("busy_after_go", o_busy, 1);
        for (int idx = 0; idx < 4; idx++) begin
            l = len;
            plan_random(l);
            if (mode == 1 && idx == 0) begin
                l = 6;
                for (int i = 0; i < 6; i++) begin
                    pv[i] = 1'b0;
                    ps[i] = 16'd0;
                    pmx[i] = 6'd0;
                    pmy[i] = 6'd0;
                end
                pv[0] = 1'b1; ps[0] = 16'd500; pmx[0] = 6'd1; pmy[0] = 6'd1;
                pv[1] = 1'b1; ps[1] = 16'd300; pmx[1] = 6'd2; pmy[1] = 6'h3D;
                pv[3] = 1'b1; ps[3] = 16'd300; pmx[3] = 6'd4; pmy[3] = 6'd4;
                pv[4] = 1'b1; ps[4] = 16'd700; pmx[4] = 6'd0; pmy[4] = 6'd0;
            end
            if (mode == 1 && idx == 1) begin
                l = 8;
                plan_random(8);
                for (int i = 0; i < 7; i++) ps[i] = ps[i] + 16'd1;
                pv[7] = 1'b1; ps[7] = 16'd0; pmx[7] = 6'd3; pmy[7] = 6'h3F;
            end
            do_mb(idx % 2, idx / 2, r, l, use_done, (mode == 1 && idx == 1) ? 20 : 0,
                  intrude && idx == 0, idx > 0);
            if (mode == 1 && idx == 0) begin
                chk("tie_sad_300", o_res_sad, 300);
                chk("tie_mv_x_2", o_res_mv_x, 2);
                chk("tie_mv_y_m3", o_res_mv_y, 6'h3D);
            end
            if (mode == 1 && idx == 1) chk("done_cycle_sad_0", o_res_sad, 0);
        end
        w = 0;
        while (o_frame_done !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("frame_done_pulse", o_frame_done, 1);
        chk("frame_done_timing", cyc - hs_cyc, 2);
        @(negedge clk);
        chk("frame_done_one_cycle", o_frame_done, 0);
        chk("busy_idle", o_busy, 0);
        chk("timeout_err_idle", o_timeout_err, exp_tmo);
        chk("me_go_count", go_cnt - go0, 4);
        chk("frame_done_count", fd_cnt - fd0, 1);
    endtask

    initial begin
        int w, fd0;
        frame_go = 1'b0;
        r_cfg = 2'd0;
        me_done = 1'b0;
        sad_valid = 1'b0;
        sad = 16'd0;
        mv_x = 6'd0;
        mv_y = 6'd0;
        res_ready = 1'b1;
        sel_b = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset_a");
        reset = 1'b1;
        @(negedge clk);

        run_frame(1, 100, 1'b1, 0, 1'b1);
        run_frame(2, 12, 1'b1, 1, 1'b0);
        run_frame(3, 7, 1'b1, 0, 1'b0);

        // Abort in the middle of MB (1,0).
        @(negedge clk);
        frame_go = 1'b1;
        r_cfg = 2'd2;
        @(negedge clk);
        frame_go = 1'b0;
        exp_tmo = 1'b0;
        plan_random(10);
        do_mb(0, 0, 2, 10, 1'b1, 0, 1'b0, 1'b0);
        w = 0;
        while (o_me_go !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("abort_me_go", o_me_go, 1);
        chk("abort_cur_base", o_cur_base, 32);
        repeat (10) begin
            @(negedge clk);
            sad_valid = 1'($urandom);
            sad = 16'($urandom_range(0, 63));
        end
        fd0 = fd_cnt;
        reset = 1'b0;
        @(negedge clk);
        sad_valid = 1'b0;
        chk_zero_outputs("abort");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_frame_done", fd_cnt - fd0, 0);
        chk("abort_busy", o_busy, 0);
        run_frame(0, 9, 1'b1, 0, 1'b0);

        // Timeout instance.
        reset = 1'b0;
        sel_b = 1'b1;
        @(negedge clk);
        chk_zero_outputs("reset_b");
        reset = 1'b1;
        @(negedge clk);
        run_frame(1, 40, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("timeout_err_sticky", o_timeout_err, 1);
        run_frame(2, 20, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
